// File: rtl/seg_disp_arb.sv
// Round-robin owner arbitration for a shared six-digit display. Each owner keeps the
// display for a minimum hold time, and a blank gap separates one owner from the next.
module seg_disp_arb #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int HOLD_MS  = 1000,
    parameter int BLANK_MS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic [23:0] data2,
    output logic [2:0]  grant,
    output logic [23:0] disp_data,
    output logic        disp_en
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC   = PW'(TICK_DIV - 1);
    localparam logic [15:0]   HOLD_C   = 16'(HOLD_MS);
    localparam logic [15:0]   HOLD_M1  = 16'(HOLD_MS - 1);
    localparam logic [15:0]   BLANK_M1 = 16'(BLANK_MS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  presc;
    logic [15:0]    ms_cnt;
    logic [15:0]    ms_sat;
    logic [1:0]     last;
    logic [1:0]     c0, c1, c2;
    logic [1:0]     win_idx;
    logic [2:0]     win_oh;
    logic           win_vld;
    logic           tick, hold_hit, blank_hit;
    logic           owner_req, other_req, chg;
    logic [23:0]    owner_data;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign tick = (presc == PRE_TC);

    // Interval ends on the tick that would bring the counter to its target, so every
    // SHOW/BLANK period is an exact multiple of the prescaler length.
    assign hold_hit  = (ms_cnt == HOLD_C) || (tick && (ms_cnt == HOLD_M1));
    assign blank_hit = tick && (ms_cnt == BLANK_M1);

    assign owner_req = |(req & grant);
    assign other_req = |(req & ~grant);
    assign ms_sat    = (state == SHOW) ? HOLD_C : 16'hFFFF;

    always_comb begin
        c0      = next_idx(last);
        c1      = next_idx(c0);
        c2      = next_idx(c1);
        win_vld = 1'b1;
        win_idx = c0;
        if (req[c0])      win_idx = c0;
        else if (req[c1]) win_idx = c1;
        else if (req[c2]) win_idx = c2;
        else              win_vld = 1'b0;
        win_oh = 3'b001 << win_idx;
    end

    always_comb begin
        owner_data = data2;
        if (last == 2'd0)      owner_data = data0;
        else if (last == 2'd1) owner_data = data1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (win_vld) state_nx = SHOW;
            SHOW:  if (!owner_req || (hold_hit && other_req)) state_nx = BLANK;
            BLANK: if (blank_hit) state_nx = win_vld ? SHOW : IDLE;
            default: state_nx = IDLE;
        endcase
        chg = (state_nx != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 3'b000;
            disp_en   <= 1'b0;
            disp_data <= 24'h0;
            presc     <= '0;
            ms_cnt    <= 16'd0;
            last      <= 2'd2;
        end else begin
            state   <= state_nx;
            disp_en <= (state_nx == SHOW);
            if (chg) begin
                presc  <= '0;
                ms_cnt <= 16'd0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && (ms_cnt != ms_sat))
                    ms_cnt <= ms_cnt + 16'd1;
            end
            if (chg && (state_nx == SHOW)) begin
                grant <= win_oh;
                last  <= win_idx;
            end else if (state_nx != SHOW) begin
                grant <= 3'b000;
            end
            if (state == SHOW)
                disp_data <= owner_data;
        end
    end

endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed scenarios for seg_disp_arb; expectations are queued per cycle when stimulus
// is driven and compared at the falling edge once the DUT reaches that cycle.
module tb_seg_disp_arb;

    localparam int CLK_FREQ = 10_000;
    localparam int HOLD_MS  = 3;
    localparam int BLANK_MS = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [23:0] data0 = 24'h0, data1 = 24'h0, data2 = 24'h0;
    logic [2:0]  grant;
    logic [23:0] disp_data;
    logic        disp_en;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;

    typedef struct {
        int          at;
        string       tag;
        logic [2:0]  g;
        logic        en;
        logic [23:0] d;
        bit          chk_d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_disp_arb #(.CLK_FREQ(CLK_FREQ), .HOLD_MS(HOLD_MS), .BLANK_MS(BLANK_MS)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data0(data0), .data1(data1), .data2(data2),
        .grant(grant), .disp_data(disp_data), .disp_en(disp_en)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (((grant & (grant - 3'd1)) === 3'b000) && (disp_en === (grant != 3'b000)))
            else begin
                failures++;
                $error("FAIL onehot_en observed grant=%b en=%b expected onehot0 and en==(grant!=0)",
                       grant, disp_en);
            end
        end
    end

    task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(input int p, input string tag, input logic [2:0] g,
                             input logic en, input logic [23:0] d, input bit chk_d);
        exp_t e;
        e.at = base + p;
        e.tag = tag;
        e.g = g;
        e.en = en;
        e.d = d;
        e.chk_d = chk_d;
        sb.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        check_val({e.tag, ".grant"}, 24'(grant), 24'(e.g));
        check_val({e.tag, ".en"}, 24'(disp_en), 24'(e.en));
        if (e.chk_d) check_val({e.tag, ".data"}, disp_data, e.d);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) compare(sb.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        check_val({tag, ".sb_left"}, 24'(sb.size()), 24'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 3'b000;
        data0 = 24'h111111;
        data1 = 24'h222222;
        data2 = 24'h333333;
        @(negedge clk);
        check_val("rst.grant", 24'(grant), 24'd0);
        check_val("rst.en", 24'(disp_en), 24'd0);
        check_val("rst.data", disp_data, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // All three requesting: full round-robin rotation with exact SHOW/BLANK lengths.
        do_reset();
        req = 3'b111;
        base = cyc;
        expect_at(1,   "rr_g0",   3'b001, 1'b1, 24'h000000, 1'b1);
        expect_at(2,   "rr_d0",   3'b001, 1'b1, 24'h111111, 1'b1);
        expect_at(30,  "rr_end0", 3'b001, 1'b1, 24'h111111, 1'b1);
        expect_at(31,  "rr_bl0",  3'b000, 1'b0, 24'h111111, 1'b1);
        expect_at(40,  "rr_bl0e", 3'b000, 1'b0, 24'h111111, 1'b1);
        expect_at(41,  "rr_g1",   3'b010, 1'b1, 24'h111111, 1'b1);
        expect_at(42,  "rr_d1",   3'b010, 1'b1, 24'h222222, 1'b1);
        expect_at(70,  "rr_end1", 3'b010, 1'b1, 24'h222222, 1'b1);
        expect_at(71,  "rr_bl1",  3'b000, 1'b0, 24'h222222, 1'b1);
        expect_at(80,  "rr_bl1e", 3'b000, 1'b0, 24'h222222, 1'b1);
        expect_at(81,  "rr_g2",   3'b100, 1'b1, 24'h222222, 1'b1);
        expect_at(82,  "rr_d2",   3'b100, 1'b1, 24'h333333, 1'b1);
        expect_at(110, "rr_end2", 3'b100, 1'b1, 24'h333333, 1'b1);
        expect_at(111, "rr_bl2",  3'b000, 1'b0, 24'h333333, 1'b1);
        expect_at(120, "rr_bl2e", 3'b000, 1'b0, 24'h333333, 1'b1);
        expect_at(121, "rr_g3",   3'b001, 1'b1, 24'h333333, 1'b1);
        expect_at(122, "rr_d3",   3'b001, 1'b1, 24'h111111, 1'b1);
        run(122);
        drain("rr");

        // Sole requester keeps the display past the hold; data tracks; late competitor forces BLANK.
        do_reset();
        data0 = 24'h123456;
        req = 3'b001;
        base = cyc;
        expect_at(1,   "solo_g",    3'b001, 1'b1, 24'h0,      1'b0);
        expect_at(2,   "solo_d",    3'b001, 1'b1, 24'h123456, 1'b1);
        expect_at(100, "solo_100",  3'b001, 1'b1, 24'h123456, 1'b1);
        expect_at(200, "solo_200",  3'b001, 1'b1, 24'h123456, 1'b1);
        run(200);
        data0 = 24'hABCDEF;
        base = cyc;
        expect_at(1, "solo_track", 3'b001, 1'b1, 24'hABCDEF, 1'b1);
        run(1);
        req = 3'b101;
        base = cyc;
        expect_at(1,  "sat_bl",   3'b000, 1'b0, 24'hABCDEF, 1'b1);
        expect_at(10, "sat_ble",  3'b000, 1'b0, 24'hABCDEF, 1'b1);
        expect_at(11, "sat_g2",   3'b100, 1'b1, 24'hABCDEF, 1'b1);
        expect_at(12, "sat_d2",   3'b100, 1'b1, 24'h333333, 1'b1);
        run(12);
        drain("solo");

        // Owner 1 drops early; a req pulse inside BLANK that is gone by BLANK end is ignored.
        do_reset();
        req = 3'b010;
        base = cyc;
        expect_at(1, "drop_g1", 3'b010, 1'b1, 24'h0,      1'b0);
        expect_at(2, "drop_d1", 3'b010, 1'b1, 24'h222222, 1'b1);
        run(5);
        req = 3'b000;
        base = cyc;
        expect_at(1,  "drop_bl",   3'b000, 1'b0, 24'h222222, 1'b1);
        expect_at(11, "drop_idle", 3'b000, 1'b0, 24'h222222, 1'b1);
        expect_at(13, "drop_idl2", 3'b000, 1'b0, 24'h222222, 1'b1);
        run(3);
        req = 3'b100;
        run(2);
        req = 3'b000;
        run(8);
        drain("drop");

        // Sub-cycle pulse in IDLE never reaches a clock edge.
        base = cyc;
        #1 req = 3'b001;
        #2 req = 3'b000;
        expect_at(1, "glitch", 3'b000, 1'b0, 24'h222222, 1'b1);
        run(2);
        drain("glitch");

        // Owner 1 drops while requester 2 is waiting: handover after the blank gap.
        do_reset();
        req = 3'b010;
        base = cyc;
        expect_at(1, "hand_g1", 3'b010, 1'b1, 24'h0, 1'b0);
        run(5);
        req = 3'b100;
        base = cyc;
        expect_at(1,  "hand_bl",  3'b000, 1'b0, 24'h222222, 1'b1);
        expect_at(10, "hand_ble", 3'b000, 1'b0, 24'h222222, 1'b1);
        expect_at(11, "hand_g2",  3'b100, 1'b1, 24'h222222, 1'b1);
        expect_at(12, "hand_d2",  3'b100, 1'b1, 24'h333333, 1'b1);
        run(12);
        drain("hand");

        // Asynchronous reset in the middle of requester 2's SHOW.
        do_reset();
        req = 3'b100;
        base = cyc;
        expect_at(1, "ar_g2", 3'b100, 1'b1, 24'h0,      1'b0);
        expect_at(2, "ar_d2", 3'b100, 1'b1, 24'h333333, 1'b1);
        run(5);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_async.grant", 24'(grant), 24'd0);
        check_val("ar_async.en", 24'(disp_en), 24'd0);
        check_val("ar_async.data", disp_data, 24'h0);
        req = 3'b101;
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        expect_at(1, "ar_g0", 3'b001, 1'b1, 24'h0,      1'b1);
        expect_at(2, "ar_d0", 3'b001, 1'b1, 24'h111111, 1'b1);
        run(2);
        drain("ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
